// File: rtl/bcs_pkg.sv
// Shared types and constants for the bubble-collapsing shifter and the line packer.
package bcs_pkg;

  localparam int unsigned LINE_WORDS = 32;
  localparam int unsigned CNT_WIDTH  = 6;
  localparam int unsigned FILL_WIDTH = 7;

  typedef logic [7:0] word_t;

  typedef enum logic {
    ST_RUN,
    ST_FLUSH
  } state_e;

endpackage

// File: rtl/comp_line_aligner.sv
// Places the low cnt words of a 32-word line at a word offset inside a 64-word vector,
// with a matching per-word write-enable mask.
module comp_line_aligner
  import bcs_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned LINE_WORDS = 32
) (
  input  logic [LINE_WORDS*WORD_WIDTH-1:0]   in_lifm_i,
  input  logic [CNT_WIDTH-1:0]               cnt_i,
  input  logic [FILL_WIDTH-1:0]              offset_i,
  output logic [2*LINE_WORDS*WORD_WIDTH-1:0] placed_o,
  output logic [2*LINE_WORDS-1:0]            wen_o
);

  localparam int unsigned BufWords = 2 * LINE_WORDS;

  logic [BufWords*WORD_WIDTH-1:0] wide_in;
  logic [BufWords-1:0]            ones;

  always_comb begin
    wide_in  = {{(LINE_WORDS*WORD_WIDTH){1'b0}}, in_lifm_i};
    placed_o = wide_in << (32'(offset_i) * WORD_WIDTH);
    // cnt_i is already saturated to LINE_WORDS, so the mask never exceeds one line.
    ones     = (BufWords'(1) << cnt_i) - BufWords'(1);
    wen_o    = ones << offset_i;
  end

endmodule

// File: rtl/comp_line_packer.sv
// Packs compacted partial lines into dense 32-word lines; in_last flushes the residue.
// Optional PACKER_ZERO_PAD_EN forces out_lifm words at index >= out_cnt to zero.
module comp_line_packer
  import bcs_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 8,
  parameter int unsigned LINE_WORDS = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LINE_WORDS*WORD_WIDTH-1:0] in_lifm,
  input  logic [CNT_WIDTH-1:0]             in_cnt,
  input  logic                             in_last,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LINE_WORDS*WORD_WIDTH-1:0] out_lifm,
  output logic [CNT_WIDTH-1:0]             out_cnt,
  output logic                             out_last
);

  localparam int unsigned BufWords = 2 * LINE_WORDS;

  state_e                         state_q, state_d;
  logic [FILL_WIDTH-1:0]          fill_q, fill_d;
  logic [BufWords*WORD_WIDTH-1:0] buf_q, buf_d, buf_shifted, placed;
  logic [BufWords-1:0]            wen;
  logic [CNT_WIDTH-1:0]           cnt_sat;
  logic [FILL_WIDTH-1:0]          shift, offset;
  logic                           in_fire, out_fire;

  // Handshake outputs depend only on state and fill, never on the opposite ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_cnt   = '0;
    out_last  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        in_ready  = (fill_q <= FILL_WIDTH'(LINE_WORDS));
        out_valid = (fill_q >= FILL_WIDTH'(LINE_WORDS));
        out_cnt   = out_valid ? CNT_WIDTH'(LINE_WORDS) : '0;
      end
      ST_FLUSH: begin
        out_valid = 1'b1;
        out_cnt   = (fill_q >= FILL_WIDTH'(LINE_WORDS)) ? CNT_WIDTH'(LINE_WORDS)
                                                       : fill_q[CNT_WIDTH-1:0];
        out_last  = (fill_q <= FILL_WIDTH'(LINE_WORDS));
      end
      default: ;
    endcase
  end

  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = out_valid & out_ready;
    cnt_sat  = (in_cnt > CNT_WIDTH'(LINE_WORDS)) ? CNT_WIDTH'(LINE_WORDS) : in_cnt;
    shift    = out_fire ? {1'b0, out_cnt} : '0;
    offset   = fill_q - shift;
  end

  comp_line_aligner #(
    .WORD_WIDTH (WORD_WIDTH),
    .LINE_WORDS (LINE_WORDS)
  ) u_aligner (
    .in_lifm_i (in_lifm),
    .cnt_i     (cnt_sat),
    .offset_i  (offset),
    .placed_o  (placed),
    .wen_o     (wen)
  );

  // Drain first, then append behind the surviving words.
  always_comb begin
    buf_shifted = buf_q >> (32'(shift) * WORD_WIDTH);
    for (int i = 0; i < BufWords; i++) begin
      buf_d[i*WORD_WIDTH +: WORD_WIDTH] = (in_fire && wen[i]) ?
          placed[i*WORD_WIDTH +: WORD_WIDTH] : buf_shifted[i*WORD_WIDTH +: WORD_WIDTH];
    end
    fill_d = fill_q - shift + (in_fire ? {1'b0, cnt_sat} : '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RUN:   if (in_fire && in_last) state_d = ST_FLUSH;
      ST_FLUSH: if (out_fire && out_last) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      fill_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      buf_q   <= buf_d;
    end
  end

`ifdef PACKER_ZERO_PAD_EN
  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) begin
      out_lifm[i*WORD_WIDTH +: WORD_WIDTH] = (i < int'(out_cnt)) ?
          buf_q[i*WORD_WIDTH +: WORD_WIDTH] : '0;
    end
  end
`else
  assign out_lifm = buf_q[LINE_WORDS*WORD_WIDTH-1:0];
`endif

endmodule

// File: doc/comp_line_packer.md
# comp_line_packer

- Stage directly downstream of the 32-lane bubble-collapsing shifter.
- Accepts one compacted line per beat: 32 words, of which the low `in_cnt` are valid.
- Concatenates successive partial lines into dense 32-word output lines, removing inter-line bubbles left by per-line compaction.
- A tile-end flush drains the residue as a short final line tagged `out_last`.

## Interface
Parameters:
- `WORD_WIDTH`, 8, bits per lifm word
- `LINE_WORDS`, 32, words per line (fixed by the shifter; only 32 supported)

Ports:
- `clk` in 1 — sole clock, rising edge
- `reset` in 1 — synchronous, active-high
- `in_valid` in 1 — input beat present
- `in_ready` out 1 — packer accepts beat
- `in_lifm` in 32*WORD_WIDTH — compacted line from shifter, word 0 at LSBs
- `in_cnt` in 6 — valid words in `in_lifm`, 0..32
- `in_last` in 1 — final beat of tile, triggers flush
- `out_valid` out 1 — output line present
- `out_ready` in 1 — consumer accepts line
- `out_lifm` out 32*WORD_WIDTH — packed line, word 0 at LSBs
- `out_cnt` out 6 — valid words in `out_lifm`, 0..32
- `out_last` out 1 — final line of tile

## Operation
- Storage: 64-word buffer `buf`; 7-bit `fill`, range 0..64. Valid words always occupy `buf[0..fill-1]` in arrival order.
- FSM with two states:
  - RUN: `in_ready = (fill <= 32)`. `out_valid = (fill >= 32)`, `out_cnt = 32`, `out_last = 0`.
  - FLUSH: `in_ready = 0`, `out_valid = 1`, `out_cnt = min(fill, 32)`, `out_last = (fill <= 32)`.
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- Per-cycle update:
  - `shift = out_fire ? out_cnt : 0`; `buf` shifts down by `shift` words.
  - On `in_fire`, input words 0..`in_cnt`-1 are written at `buf[fill - shift ...]`.
  - `fill_next = fill - shift + (in_fire ? in_cnt : 0)`.
- `in_cnt > 32` is illegal and saturates to 32. `in_cnt = 0` appends nothing; it is still a legal beat and may carry `in_last`.
- Transitions:
  - RUN→FLUSH on `in_fire & in_last`.
  - FLUSH→RUN on `out_fire & out_last`.
- Empty flush (`fill = 0` in FLUSH) emits one line with `out_cnt = 0`, `out_last = 1`. Every tile therefore ends with exactly one `out_last` line.
- Simultaneous `in_fire` and `out_fire` in RUN is legal; ordering is preserved (shift first, then append).
- `in_ready` does not depend on `out_ready`: no combinational ready-to-ready path.
- `out_lifm` words at index ≥ `out_cnt`: see Configuration.
- `out_*` signals hold stable while `out_valid & ~out_ready`.

## Timing
- Reset values:
  - `fill = 0`, state RUN, `buf` zeroed.
  - Outputs: `out_valid = 0`, `out_cnt = 0`, `out_last = 0`, `out_lifm = 0`, `in_ready = 1`.
- Reset mid-tile discards all buffered words; no flush line is produced.
- All outputs are driven from registers (`buf`, `fill`, state) through simple muxing only.
- Latency: a beat accepted at edge N that makes `fill ≥ 32` (or that carries `in_last`) gives `out_valid` high after edge N, i.e. in cycle N+1.
- Throughput: one 32-word output line per cycle in steady state when the input averages ≥ 32 words per beat.
- Backpressure is held off by `fill ≤ 32`: a beat accepted at `fill = 32` reaches at most 64 words, so the buffer never overflows.

## Configuration
- `PACKER_ZERO_PAD_EN`:
  - Defined: `out_lifm` words at index ≥ `out_cnt` are forced to 0. Costs one AND mask per word.
  - Undefined: those words carry stale buffer contents and are don't-care. The bench must mask them before comparing.

## Structure
- Shared package `bcs_pkg` holds:
  - `LINE_WORDS = 32`, `CNT_WIDTH = 6`, `FILL_WIDTH = 7`
  - state enum `{ST_RUN, ST_FLUSH}`
  - `word_t` typedef
- The shifter is retrofitted later to import the same package.
- One sub-module, `comp_line_aligner`: combinational barrel placement of the 32 input words at word offset `fill - shift` (0..32) into a 64-word vector, plus a per-word write-enable mask.
- The packer top instantiates one `comp_line_aligner` and holds the buffer registers, `fill` and the FSM.

## Test plan
- Reset, then beats of `in_cnt` 20, 20 → after the second beat one line with `out_cnt = 32` (words 0..31 in order) and `fill = 8`.
- Beat `in_cnt = 32` every cycle with `out_ready = 1` → `out_valid` continuous from cycle 2, one line per cycle, `in_ready` never drops.
- `in_cnt` 32, 32 with `out_ready = 0` → `fill = 64`, `in_ready = 0`. Release `out_ready` → two lines of 32, in order.
- `in_cnt` 10, then `in_cnt = 5` with `in_last` → one line with `out_cnt = 15`, `out_last = 1`. With `PACKER_ZERO_PAD_EN`, words 15..31 read 0. State returns to RUN.
- Flush at `fill = 0` (`in_cnt = 0`, `in_last`) → one line with `out_cnt = 0`, `out_last = 1`. Flush at `fill = 40` → a line of 32 (`out_last = 0`), then a line of 8 (`out_last = 1`).
- Assert `reset` while in FLUSH with `fill = 20` → next cycle `out_valid = 0`, `fill = 0`, `in_ready = 1`, and no stale line appears afterwards.
